// File: rtl/cpu_clock_sequencer_pkg.sv
// Shared definitions for the CPU clock sequencer: sequencer states and
// key request decoding with its priority order.
package cpu_clock_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2,
    ST_STEP = 2'd3
  } seq_state_e;

  typedef enum logic [2:0] {
    REQ_NONE  = 3'd0,
    REQ_RESET = 3'd1,
    REQ_HALT  = 3'd2,
    REQ_RUN   = 3'd3,
    REQ_STEP  = 3'd4
  } req_e;

  // Only the highest-priority request of a cycle is acted on: reset > halt > run > step.
  function automatic req_e pick_request(input logic rst_r, input logic halt_r,
                                        input logic run_r, input logic step_r);
    if (rst_r)       return REQ_RESET;
    else if (halt_r) return REQ_HALT;
    else if (run_r)  return REQ_RUN;
    else if (step_r) return REQ_STEP;
    else             return REQ_NONE;
  endfunction

endpackage

// File: rtl/cpu_clock_sequencer_key_conditioner.sv
// Board key conditioning: two-flop synchroniser, level debounce and a
// single-cycle pulse on each accepted press.
module key_conditioner #(
  parameter int DEBOUNCE = 120000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic press_o
);

  localparam int            CW       = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DEBOUNCE - 1);

  logic          meta_q;
  logic          sync_q;
  logic          level_q;
  logic          press_q;
  logic [CW-1:0] cnt_q;

  // cnt_q counts down the samples that disagree with the accepted level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= CNT_LOAD;
    end else begin
      meta_q  <= key_i;
      sync_q  <= meta_q;
      press_q <= 1'b0;
      if (sync_q == level_q) begin
        cnt_q <= CNT_LOAD;
      end else if (cnt_q == '0) begin
        level_q <= sync_q;
        press_q <= sync_q;
        cnt_q   <= CNT_LOAD;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/cpu_clock_sequencer.sv
// Two-phase slow CPU clock generator with power-on/key reset sequencing
// and run/halt/single-step control from the board keys.
module cpu_clock_sequencer
  import cpu_clock_sequencer_pkg::*;
#(
  parameter int CLOCKDELAY    = 10000,
  parameter int POWERUP_DELAY = 1000000,
  parameter int RESET_HOLD    = 1000,
  parameter int DEBOUNCE      = 120000,
  parameter int START_RUNNING = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_run,
  input  logic        key_halt,
  input  logic        key_step,
  input  logic        key_reset,
  output logic        slowclk,
  output logic        slowclk90,
  output logic        reset_bar,
  output logic        running,
  output logic        halted,
  output logic [15:0] cycle_count
);

  localparam int HALF     = CLOCKDELAY + 1;
  localparam int PERIOD   = 2 * HALF;
  localparam int LAG      = HALF / 2;
  localparam int PW       = $clog2(PERIOD);
  localparam int HOLD_MAX = (POWERUP_DELAY > RESET_HOLD) ? POWERUP_DELAY : RESET_HOLD;
  localparam int HW       = $clog2(HOLD_MAX + 1);

  localparam logic [PW-1:0] PH_LAST  = PW'(PERIOD - 1);
  localparam logic [PW-1:0] PH_HALF  = PW'(HALF);
  localparam logic [PW-1:0] PH_LAG   = PW'(LAG);
  localparam logic [PW-1:0] PH_BOUND = PW'(LAG + HALF);
  localparam logic [HW-1:0] HOLD_PU  = HW'(POWERUP_DELAY);
  localparam logic [HW-1:0] HOLD_KEY = HW'(RESET_HOLD);

  // state   | meaning
  // HOLD    | reset_bar low, clocks low, hold counter running down
  // RUN     | free-running two-phase clock
  // HALT    | clocks parked at a cycle boundary, phase frozen
  // STEP    | one full cycle, then back to HALT at the next boundary
  seq_state_e    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [PW-1:0] ph_q, ph_d, ph_next;
  logic [15:0]   cycle_count_q, cycle_count_d;
  logic          halt_pend_q, halt_pend_d;
  logic          reset_bar_q, reset_bar_d;
  logic          slowclk_q, slowclk90_q, running_q, halted_q;
  logic          run_p, halt_p, step_p, reset_p;
  logic          halt_now;
  req_e          req;

  key_conditioner #(.DEBOUNCE(DEBOUNCE)) u_key_run (
    .clk(clk), .rst(reset), .key_i(key_run), .press_o(run_p));
  key_conditioner #(.DEBOUNCE(DEBOUNCE)) u_key_halt (
    .clk(clk), .rst(reset), .key_i(key_halt), .press_o(halt_p));
  key_conditioner #(.DEBOUNCE(DEBOUNCE)) u_key_step (
    .clk(clk), .rst(reset), .key_i(key_step), .press_o(step_p));
  key_conditioner #(.DEBOUNCE(DEBOUNCE)) u_key_reset (
    .clk(clk), .rst(reset), .key_i(key_reset), .press_o(reset_p));

  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    ph_d          = ph_q;
    cycle_count_d = cycle_count_q;
    halt_pend_d   = halt_pend_q;
    reset_bar_d   = reset_bar_q;
    halt_now      = 1'b0;
    req           = pick_request(reset_p, halt_p, run_p, step_p);
    ph_next       = (ph_q == PH_LAST) ? '0 : ph_q + 1'b1;

    if (req == REQ_RESET) begin
      state_d       = ST_HOLD;
      hold_d        = HOLD_KEY;
      reset_bar_d   = 1'b0;
      cycle_count_d = '0;
      halt_pend_d   = 1'b0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (hold_q == '0) begin
            reset_bar_d = 1'b1;
            if (START_RUNNING != 0) begin
              state_d       = ST_RUN;
              ph_d          = '0;
              cycle_count_d = 16'd1;
            end else begin
              state_d       = ST_HALT;
              ph_d          = PH_BOUND;
              cycle_count_d = '0;
            end
          end else begin
            hold_d = hold_q - 1'b1;
          end
        end
        ST_RUN: begin
          ph_d = ph_next;
          if (ph_next == '0) cycle_count_d = cycle_count_q + 16'd1;
          halt_now = halt_pend_q || (req == REQ_HALT);
          if (halt_now && ph_next == PH_BOUND) begin
            state_d     = ST_HALT;
            halt_pend_d = 1'b0;
          end else begin
            halt_pend_d = halt_now;
          end
        end
        ST_STEP: begin
          ph_d = ph_next;
          if (ph_next == '0) cycle_count_d = cycle_count_q + 16'd1;
          if (req == REQ_RUN)              state_d = ST_RUN;
          else if (ph_next == PH_BOUND)    state_d = ST_HALT;
        end
        ST_HALT: begin
          if (req == REQ_RUN)       state_d = ST_RUN;
          else if (req == REQ_STEP) state_d = ST_STEP;
        end
      endcase
    end
  end

  // Clock outputs are registered decodes of the next phase, so they switch
  // on the same edge as the state (and are forced low on entry to HOLD).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_HOLD;
      hold_q        <= HOLD_PU;
      ph_q          <= '0;
      cycle_count_q <= '0;
      halt_pend_q   <= 1'b0;
      reset_bar_q   <= 1'b0;
      slowclk_q     <= 1'b0;
      slowclk90_q   <= 1'b0;
      running_q     <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      ph_q          <= ph_d;
      cycle_count_q <= cycle_count_d;
      halt_pend_q   <= halt_pend_d;
      reset_bar_q   <= reset_bar_d;
      slowclk_q     <= (state_d != ST_HOLD) && (ph_d < PH_HALF);
      slowclk90_q   <= (state_d != ST_HOLD) && (ph_d >= PH_LAG) && (ph_d < PH_BOUND);
      running_q     <= (state_d == ST_RUN);
      halted_q      <= (state_d == ST_HALT);
    end
  end

  assign slowclk     = slowclk_q;
  assign slowclk90   = slowclk90_q;
  assign reset_bar   = reset_bar_q;
  assign running     = running_q;
  assign halted      = halted_q;
  assign cycle_count = cycle_count_q;

endmodule
